// File: rtl/rgb2bram_pkg.sv
// rgb2bram_pkg: frame-buffer geometry and writer state encoding shared by the
// Ethernet line writer and the VGA scan-out stage.
package rgb2bram_pkg;

    localparam int H_PIX    = 320;
    localparam int V_LINES  = 180;
    localparam int FB_DEPTH = H_PIX * V_LINES;
    localparam int ADDR_W   = 20;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        PIXEL,
        DROP
    } state_t;

endpackage

// File: rtl/rgb2bram_packer.sv
// rgb_packer: collects R,G,B bytes into one 24-bit pixel. The strobe fires
// combinationally on the B byte so the writer can register the BRAM write on
// the same edge. A synchronous clear drops any partial pixel.
module rgb_packer (
    input  logic        clk,
    input  logic        xrst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        pix_stb,
    output logic [23:0] pixel
);

    logic [1:0] phase;
    logic [7:0] r_q;
    logic [7:0] g_q;

    // byte phase 0,1,2 = R,G,B; clear wins over a simultaneous byte
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            phase <= 2'd0;
            r_q   <= 8'd0;
            g_q   <= 8'd0;
        end else if (clr) begin
            phase <= 2'd0;
        end else if (en) begin
            case (phase)
                2'd0: begin
                    r_q   <= data;
                    phase <= 2'd1;
                end
                2'd1: begin
                    g_q   <= data;
                    phase <= 2'd2;
                end
                default: phase <= 2'd0;
            endcase
        end
    end

    assign pix_stb = en && (phase == 2'd2);
    assign pixel   = {r_q, g_q, data};

endmodule

// File: rtl/rgb2bram.sv
// rgb2bram: writes one received video line per packet into the RGB frame
// buffer. Packet = 2-byte big-endian line index + H_PIX*3 pixel bytes.
// Optional build macro RGB2BRAM_STATS_EN enables the rejected-packet counter
// on err_cnt; without it err_cnt is tied to zero.
// The line base uses line*256 + line*64, i.e. it assumes H_PIX = 320.
module rgb2bram #(
    parameter int H_PIX   = rgb2bram_pkg::H_PIX,
    parameter int V_LINES = rgb2bram_pkg::V_LINES
) (
    input  logic        clk,
    input  logic        xrst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        ram_we,
    output logic [19:0] ram_addr,
    output logic [23:0] ram_wdata,
    output logic        line_done,
    output logic        frame_done,
    output logic [15:0] err_cnt
);

    import rgb2bram_pkg::*;

    state_t              state;
    logic [7:0]          line_hi;
    logic [15:0]         line;
    logic [15:0]         line_nxt;
    logic [8:0]          x;
    logic [ADDR_W-1:0]   base;
    logic                done_pend;
    logic                pk_en;
    logic                pk_clr;
    logic                pix_stb;
    logic [23:0]         pixel;
    logic                last_pix;
    logic                err_ev;

    rgb_packer u_packer (
        .clk     (clk),
        .xrst    (xrst),
        .clr     (pk_clr),
        .en      (pk_en),
        .data    (in_data),
        .pix_stb (pix_stb),
        .pixel   (pixel)
    );

    // packer control and rejected-packet detection for the current byte
    always_comb begin
        line_nxt = {line_hi, in_data};
        last_pix = (x == 9'(H_PIX - 1));
        pk_en    = in_valid && (state == PIXEL) && !in_sop;
        pk_clr   = in_valid && ((state == HDR_LO) ||
                                ((state == PIXEL) && (in_sop || in_eop)));
        err_ev   = 1'b0;
        case (state)
            IDLE:   err_ev = in_valid && in_sop && in_eop;
            HDR_HI: err_ev = in_valid && (in_sop || in_eop);
            HDR_LO: err_ev = in_valid && (in_sop || in_eop ||
                                          (line_nxt >= 16'(V_LINES)));
            PIXEL:  err_ev = in_valid && (in_sop ||
                                          (in_eop && !(pix_stb && last_pix)));
            DROP:   err_ev = in_valid && in_sop;
            default: err_ev = 1'b0;
        endcase
    end

    // packet state machine with registered BRAM write and completion strobes
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= IDLE;
            line_hi    <= 8'd0;
            line       <= 16'd0;
            x          <= 9'd0;
            base       <= '0;
            done_pend  <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= 20'd0;
            ram_wdata  <= 24'd0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                // an unexpected sop aborts and starts a fresh header
                if (in_sop && (state != IDLE)) begin
                    done_pend <= 1'b0;
                    line_hi   <= in_data;
                    state     <= in_eop ? IDLE : HDR_LO;
                end else begin
                    case (state)
                        IDLE: begin
                            if (in_sop && !in_eop) begin
                                line_hi <= in_data;
                                state   <= HDR_LO;
                            end
                        end
                        HDR_HI: begin
                            if (in_eop) begin
                                state <= IDLE;
                            end else begin
                                line_hi <= in_data;
                                state   <= HDR_LO;
                            end
                        end
                        HDR_LO: begin
                            if (in_eop) begin
                                state <= IDLE;
                            end else if (err_ev) begin
                                done_pend <= 1'b0;
                                state     <= DROP;
                            end else begin
                                line  <= line_nxt;
                                base  <= (ADDR_W'(line_nxt) << 8) + (ADDR_W'(line_nxt) << 6);
                                x     <= 9'd0;
                                state <= PIXEL;
                            end
                        end
                        PIXEL: begin
                            if (pix_stb) begin
                                ram_we    <= 1'b1;
                                ram_addr  <= base + ADDR_W'(x);
                                ram_wdata <= pixel;
                                if (last_pix) begin
                                    if (in_eop) begin
                                        line_done  <= 1'b1;
                                        frame_done <= (line == 16'(V_LINES - 1));
                                        state      <= IDLE;
                                    end else begin
                                        done_pend <= 1'b1;
                                        state     <= DROP;
                                    end
                                end else begin
                                    x <= x + 9'd1;
                                    if (in_eop) begin
                                        state <= IDLE;
                                    end
                                end
                            end else if (in_eop) begin
                                state <= IDLE;
                            end
                        end
                        DROP: begin
                            if (in_eop) begin
                                line_done  <= done_pend;
                                frame_done <= done_pend && (line == 16'(V_LINES - 1));
                                done_pend  <= 1'b0;
                                state      <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef RGB2BRAM_STATS_EN
    // saturating count of rejected packets
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            err_cnt <= 16'd0;
        end else if (err_ev && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rgb2bram.sv
// tb_rgb2bram: packet-level reference model feeding write/done scoreboards;
// a negedge monitor pops and compares whatever the writer emits.
module tb_rgb2bram;

    typedef struct packed {
        logic [19:0] addr;
        logic [23:0] data;
    } wr_t;

    typedef struct packed {
        logic with_write;
        logic frame;
    } done_t;

`ifdef RGB2BRAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        xrst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic        ram_we;
    logic [19:0] ram_addr;
    logic [23:0] ram_wdata;
    logic        line_done;
    logic        frame_done;
    logic [15:0] err_cnt;

    int    checks = 0;
    int    errors = 0;
    int    exp_err = 0;
    wr_t   wq[$];
    done_t dq[$];

    rgb2bram dut (
        .clk        (clk),
        .xrst       (xrst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .line_done  (line_done),
        .frame_done (frame_done),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every write and every done strobe must match the scoreboard head
    always @(negedge clk) begin
        if (xrst === 1'b1) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0d required=none", ram_addr);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e.addr));
                    check("wr_data", 32'(ram_wdata), 32'(e.data));
                end
            end
            if (line_done || frame_done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%0b%0b required=none", line_done, frame_done);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    check("line_done", 32'(line_done), 32'd1);
                    check("frame_done", 32'(frame_done), 32'(d.frame));
                    check("done_with_write", 32'(ram_we), 32'(d.with_write));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sop   = 1'($urandom);
        in_eop   = 1'($urandom);
    endtask

    // One packet; expectations come from the packet-level rules only.
    // A packet sent without eop is assumed to be cut short by the next sop.
    task automatic send_pkt(input int line, input int npay, input bit eop_end, input bit pat);
        logic [7:0] pay[$];
        logic [15:0] lv;
        int npix;
        lv = 16'(line);
        for (int n = 0; n < npay; n++) begin
            int p;
            p = n / 3;
            if (pat) pay.push_back((n % 3 == 0) ? 8'(p) : ((n % 3 == 1) ? 8'h55 : 8'hAA));
            else     pay.push_back(8'($urandom));
        end
        if (line < 180) begin
            npix = (npay / 3 > 320) ? 320 : npay / 3;
            for (int p = 0; p < npix; p++) begin
                wr_t w;
                w.addr = 20'(line * 320 + p);
                w.data = {pay[3*p], pay[3*p+1], pay[3*p+2]};
                wq.push_back(w);
            end
            if (npay >= 960 && eop_end) begin
                done_t d;
                d.with_write = (npay == 960);
                d.frame      = (line == 179);
                dq.push_back(d);
            end
            if (npay < 960 && eop_end) exp_err++;
        end else begin
            exp_err++;
        end
        if (!eop_end) exp_err++;
        send_byte(lv[15:8], 1'b1, 1'b0);
        send_byte(lv[7:0], 1'b0, 1'b0);
        for (int i = 0; i < npay; i++) begin
            if ($urandom_range(0, 7) == 0) idle_cycle();
            send_byte(pay[i], 1'b0, eop_end && (i == npay - 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic chk_err(input string name);
        repeat (3) idle_cycle();
        check(name, 32'(err_cnt), STATS ? 32'((exp_err > 65535) ? 65535 : exp_err) : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xrst     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        xrst = 1'b1;
        repeat (2) idle_cycle();

        send_pkt(0, 960, 1'b1, 1'b1);
        chk_err("err_line0");
        send_pkt(179, 960, 1'b1, 1'b0);
        chk_err("err_line179");
        send_pkt(180, 960, 1'b1, 1'b0);
        chk_err("err_line180");
        send_pkt(5, 301, 1'b1, 1'b0);
        chk_err("err_short_line5");
        send_pkt(2, 498, 1'b0, 1'b0);
        send_pkt(3, 960, 1'b1, 1'b0);
        chk_err("err_sop_abort");

        // partial line 10, then an asynchronous reset between clock edges
        send_pkt(10, 398, 1'b0, 1'b0);
        repeat (2) idle_cycle();
        #2;
        xrst = 1'b0;
        #1;
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_addr", 32'(ram_addr), 32'd0);
        check("midrst_wdata", 32'(ram_wdata), 32'd0);
        check("midrst_line_done", 32'(line_done), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        exp_err = 0;
        @(negedge clk);
        #2;
        xrst = 1'b1;
        send_pkt(10, 960, 1'b1, 1'b0);
        chk_err("err_after_reset");

        send_pkt(7, 965, 1'b1, 1'b0);
        chk_err("err_trailing_bytes");

        for (int k = 0; k < 14; k++) begin
            int  ln;
            int  np;
            bit  eo;
            ln = ($urandom_range(0, 5) == 0) ? $urandom_range(180, 300) : $urandom_range(0, 179);
            case ($urandom_range(0, 3))
                0:       np = 960;
                1:       np = 960 + $urandom_range(1, 6);
                2:       np = $urandom_range(1, 959);
                default: np = 960;
            endcase
            eo = (k == 13) || ($urandom_range(0, 4) != 0);
            send_pkt(ln, np, eo, 1'b0);
            if (eo) chk_err("err_random");
        end

        repeat (6) idle_cycle();
        check("writes_drained", 32'(wq.size()), 32'd0);
        check("dones_drained", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb2bram.md
# rgb2bram

Frame-buffer writer between the Ethernet RX payload parser and the 320x180 RGB frame-buffer BRAM read by the VGA scan-out stage. Each received packet carries one video line: a 2-byte big-endian line index followed by 960 pixel bytes (R,G,B per pixel). The block packs bytes into 24-bit pixels and writes them to BRAM address `line*320 + x`. It raises per-line and per-frame completion strobes, and rejects malformed or out-of-range packets.

## Interface
Parameters:
- `H_PIX`, 320, pixels per line.
- `V_LINES`, 180, lines per frame; frame-buffer depth is `H_PIX*V_LINES` = 57600.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `xrst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a payload byte is present this cycle.
- `in_data`  in  8  payload byte.
- `in_sop`  in  1  first byte of a packet; qualified by `in_valid`.
- `in_eop`  in  1  last byte of a packet; qualified by `in_valid`.
- `ram_we`  out  1  BRAM write enable.
- `ram_addr`  out  20  BRAM write address, range 0..57599.
- `ram_wdata`  out  24  pixel value `{R,G,B}`.
- `line_done`  out  1  one-cycle pulse when a complete line has been written.
- `frame_done`  out  1  one-cycle pulse together with `line_done` when line `V_LINES-1` completes.
- `err_cnt`  out  16  count of rejected packets; present only when the stats feature is enabled.

## Operation
- The block never back-pressures the source; it accepts every byte on which `in_valid`=1.
- State machine states: IDLE, HDR_HI, HDR_LO, PIXEL, DROP.
- IDLE: a byte with `in_valid & in_sop` loads `line[15:8]` and moves to HDR_LO. Bytes without `in_sop` are ignored.
- HDR_LO: the next byte loads `line[7:0]`.
  - If the line index is below `V_LINES`, move to PIXEL and clear `x` and the byte phase.
  - Otherwise count an error and move to DROP.
- PIXEL: byte phase cycles 0,1,2 through R, G, B. The byte at phase 2 issues a write at `line*H_PIX + x`, then `x` increments.
  - The write of pixel `x = H_PIX-1` completes the line.
  - If that byte also has `in_eop`, pulse `line_done` (and `frame_done` when `line = V_LINES-1`) and return to IDLE.
  - Otherwise move to DROP. The trailing bytes are ignored and the line is still reported done when `in_eop` arrives.
- DROP: ignore bytes until `in_eop`, then go to IDLE.
- Abort conditions:
  - `in_eop` in PIXEL before the line is complete.
  - `in_sop` in any state other than IDLE.
  - `in_eop` in HDR_HI or HDR_LO.
- On abort: count one error, discard any partial pixel, and issue no `line_done`. Pixels already written stay in the BRAM.
- On an `in_sop` abort, the same byte starts a new header.
- A single-byte packet (`in_sop & in_eop`) counts as one error and the block stays in IDLE.
- Address arithmetic: `line*H_PIX` is computed once at HDR_LO as `(line<<8)+(line<<6)` into a 20-bit base; pixel writes use base+`x`. No address can exceed 57599.
- `err_cnt` saturates at 16'hFFFF.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `line_done`=0, `frame_done`=0, `err_cnt`=0, state IDLE.
- Write latency: `ram_we`, `ram_addr` and `ram_wdata` are registered and assert on the cycle after the B byte is accepted. `ram_we` is high for exactly one cycle per pixel.
- `line_done` and `frame_done` assert on the same cycle as the final pixel's `ram_we` when that pixel's byte carries `in_eop`. Otherwise they assert on the cycle after `in_eop` in DROP.
- Sustained rate is one byte per cycle, so there is at most one write every 3 cycles.
- Reset asserted mid-line immediately returns to IDLE with all outputs low. Partial writes already issued stay in the BRAM.

## Configuration
- `RGB2BRAM_STATS_EN` defined: the `err_cnt` counter is instantiated and the port is driven.
- Not defined: no counter logic is built and `err_cnt` is tied to 0. Error detection and state behaviour are identical in both builds.

## Structure
- Shared package holds:
  - `H_PIX`, `V_LINES` and `FB_DEPTH` constants, also used by the scan-out stage.
  - Address width constant 20.
  - The state enum.
- One sub-module, `rgb_packer`: a byte-phase counter plus R/G registers that emits a 24-bit pixel and a strobe. It has a synchronous clear used on abort.

## Test plan
- Line 0 with 960 bytes (pixel n = `{n[7:0],8'h55,8'hAA}`) and `in_eop` on the last byte: 320 writes at addresses 0..319 with matching data, then `line_done`=1 and `frame_done`=0.
- Line 179 complete: writes at addresses 57280..57599, then `line_done` and `frame_done` pulse on the same cycle.
- Line index 180: no writes, `err_cnt` +1, block returns to IDLE at `in_eop`.
- Line 5 with `in_eop` after 301 bytes: exactly 100 writes at 1600..1699, no `line_done`, `err_cnt` +1.
- `in_sop` arrives at byte 500 of line 2, followed by a valid line 3: the line-2 writes stop, `err_cnt` +1, and line 3 is written correctly at 960..1279.
- `xrst` pulsed during the PIXEL state of line 10: outputs go to 0 immediately. A subsequent full line 10 writes all 320 pixels at 3200..3519.
